// File: rtl/mem_arbiter_if.sv
// Request/grant and memory-port bundle shared by the loader, CPU, GPU, arbiter and memory.
interface mem_arbiter_if #(
   parameter int unsigned ADDR_W = 12
);
   localparam int unsigned DATA_W = 8;

   // loader: write-only requester
   logic              ld_req;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_wdata;

   // CPU: read/write requester with bus-lock hint
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_lock;

   // GPU: sprite-fetch reads
   logic              gpu_req;
   logic [ADDR_W-1:0] gpu_addr;

   // grants and read responses
   logic              ld_gnt;
   logic              cpu_gnt;
   logic              gpu_gnt;
   logic              cpu_rvalid;
   logic              gpu_rvalid;
   logic [DATA_W-1:0] rdata;
   logic              busy;

   // memory ports
   logic              mem_read;
   logic [ADDR_W-1:0] mem_read_addr;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_write_addr;
   logic [DATA_W-1:0] mem_write_data;
   logic [DATA_W-1:0] mem_read_data;

   // arbiter side
   modport slave (
      input  ld_req, ld_addr, ld_wdata,
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_lock,
      input  gpu_req, gpu_addr,
      input  mem_read_data,
      output ld_gnt, cpu_gnt, gpu_gnt,
      output cpu_rvalid, gpu_rvalid, rdata, busy,
      output mem_read, mem_read_addr,
      output mem_write, mem_write_addr, mem_write_data
   );

   // requester/memory side
   modport master (
      output ld_req, ld_addr, ld_wdata,
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_lock,
      output gpu_req, gpu_addr,
      output mem_read_data,
      input  ld_gnt, cpu_gnt, gpu_gnt,
      input  cpu_rvalid, gpu_rvalid, rdata, busy,
      input  mem_read, mem_read_addr,
      input  mem_write, mem_write_addr, mem_write_data
   );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: loader has absolute priority, CPU and GPU share
// round-robin, and the CPU can lock the GPU out while holding cpu_lock.
// Grants and memory commands are combinational; read responses come one cycle later.
module mem_arbiter #(
   parameter int unsigned ADDR_W = 12
) (
   input  logic         clk,
   input  logic         rst_n,
   mem_arbiter_if.slave bus
);
   localparam int unsigned DATA_W = 8;

   typedef enum logic { OPEN = 1'b0, LOCKED = 1'b1 } lock_state_e;
   typedef enum logic [1:0] { SEL_NONE, SEL_LD, SEL_CPU, SEL_GPU } sel_e;

   lock_state_e       state_q, state_d;
   logic              rr_q, rr_d;
   logic              cpu_rvalid_q, gpu_rvalid_q;
   sel_e              sel_c;
   logic              gpu_eligible_c;
   logic              mem_read_c, mem_write_c;
   logic [ADDR_W-1:0] rd_addr_c, wr_addr_c;
   logic [DATA_W-1:0] wr_data_c;

   // Winner selection: loader first, then CPU/GPU by rr; GPU excluded while locked.
   always_comb begin
      sel_c          = SEL_NONE;
      gpu_eligible_c = bus.gpu_req && (state_q == OPEN);
      if (!rst_n) begin
         sel_c = SEL_NONE;
      end else if (bus.ld_req) begin
         sel_c = SEL_LD;
      end else if (bus.cpu_req && gpu_eligible_c) begin
         sel_c = rr_q ? SEL_GPU : SEL_CPU;
      end else if (bus.cpu_req) begin
         sel_c = SEL_CPU;
      end else if (gpu_eligible_c) begin
         sel_c = SEL_GPU;
      end
   end

   // Lock state and round-robin pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= OPEN;
         rr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
      end
   end

   // Next lock state and pointer; loader grants and idle cycles leave rr alone.
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      case (state_q)
         OPEN:    if (sel_c == SEL_CPU && bus.cpu_lock) state_d = LOCKED;
         LOCKED:  if (!bus.cpu_lock) state_d = OPEN;
         default: state_d = OPEN;
      endcase
      if (sel_c == SEL_CPU) begin
         rr_d = 1'b1;
      end else if (sel_c == SEL_GPU) begin
         rr_d = 1'b0;
      end
   end

   // Read-response pending flags, one cycle behind the read grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cpu_rvalid_q <= 1'b0;
         gpu_rvalid_q <= 1'b0;
      end else begin
         cpu_rvalid_q <= (sel_c == SEL_CPU) && !bus.cpu_we;
         gpu_rvalid_q <= (sel_c == SEL_GPU);
      end
   end

   // Memory command from the winner; at most one of read/write.
   always_comb begin
      mem_read_c  = 1'b0;
      mem_write_c = 1'b0;
      rd_addr_c   = bus.cpu_addr;
      wr_addr_c   = bus.cpu_addr;
      wr_data_c   = bus.cpu_wdata;
      case (sel_c)
         SEL_LD: begin
            mem_write_c = 1'b1;
            wr_addr_c   = bus.ld_addr;
            wr_data_c   = bus.ld_wdata;
         end
         SEL_CPU: begin
            if (bus.cpu_we) begin
               mem_write_c = 1'b1;
            end else begin
               mem_read_c = 1'b1;
            end
         end
         SEL_GPU: begin
            mem_read_c = 1'b1;
            rd_addr_c  = bus.gpu_addr;
         end
         default: ;
      endcase
   end

   assign bus.ld_gnt         = (sel_c == SEL_LD);
   assign bus.cpu_gnt        = (sel_c == SEL_CPU);
   assign bus.gpu_gnt        = (sel_c == SEL_GPU);
   assign bus.mem_read       = mem_read_c;
   assign bus.mem_read_addr  = rd_addr_c;
   assign bus.mem_write      = mem_write_c;
   assign bus.mem_write_addr = wr_addr_c;
   assign bus.mem_write_data = wr_data_c;
   assign bus.cpu_rvalid     = cpu_rvalid_q;
   assign bus.gpu_rvalid     = gpu_rvalid_q;
   assign bus.rdata          = bus.mem_read_data;
   assign bus.busy           = bus.ld_req | bus.cpu_req | bus.gpu_req |
                               cpu_rvalid_q | gpu_rvalid_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of hand-derived vectors, reset corner sequences,
// then randomized requesters checked against a rule-level reference model.
module tb_mem_arbiter;
   localparam int unsigned AW = 12;

   typedef struct packed {
      logic          rst_n;
      logic          ld_req;
      logic [AW-1:0] ld_addr;
      logic [7:0]    ld_wdata;
      logic          cpu_req;
      logic          cpu_we;
      logic [AW-1:0] cpu_addr;
      logic [7:0]    cpu_wdata;
      logic          cpu_lock;
      logic          gpu_req;
      logic [AW-1:0] gpu_addr;
   } in_t;

   typedef struct packed {
      logic [2:0]    gnt;     // {ld, cpu, gpu}
      logic          rd;
      logic          wr;
      logic [AW-1:0] addr;
      logic [7:0]    wdata;
      logic          cpu_rv;
      logic          gpu_rv;
      logic [7:0]    rdata;
      logic          busy;
   } out_t;

   typedef struct packed {
      in_t  in;
      out_t exp;
   } vec_t;

   typedef struct {
      int         due;
      bit         is_gpu;
      logic [7:0] data;
   } resp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(AW)) bus ();
   mem_arbiter #(.ADDR_W(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   logic [2:0] s_gnt = 3'b000;

   // reference model state
   bit         m_rr     = 1'b0;
   bit         m_locked = 1'b0;
   resp_t      m_q[$];
   logic [7:0] ref_mem [int];

   function automatic logic [7:0] init_val(input logic [AW-1:0] a);
      case (a)
         12'h200: return 8'hA2;
         12'h123: return 8'h7E;
         12'h124: return 8'h24;
         12'h300: return 8'h30;
         12'h301: return 8'h31;
         default: return a[7:0] ^ 8'h5A;
      endcase
   endfunction

   // memory attached to the arbiter: one-cycle read latency
   logic [7:0] tb_mem  [1 << AW];
   bit         tb_seen [1 << AW];
   logic [7:0] rd_q;
   always @(posedge clk) begin
      if (bus.mem_write) begin
         tb_mem[bus.mem_write_addr]  <= bus.mem_write_data;
         tb_seen[bus.mem_write_addr] <= 1'b1;
      end
      if (bus.mem_read)
         rd_q <= tb_seen[bus.mem_read_addr] ? tb_mem[bus.mem_read_addr]
                                            : init_val(bus.mem_read_addr);
   end
   assign bus.mem_read_data = rd_q;

   function automatic logic [7:0] ref_rd(input logic [AW-1:0] a);
      if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
      return init_val(a);
   endfunction

   function automatic in_t fn_in(input logic ld, input logic [AW-1:0] la, input logic [7:0] ldd,
                                 input logic c, input logic cwe, input logic [AW-1:0] ca,
                                 input logic [7:0] cd, input logic cl,
                                 input logic g, input logic [AW-1:0] ga);
      in_t v;
      v.rst_n = 1'b1;  v.ld_req = ld;   v.ld_addr = la;  v.ld_wdata = ldd;
      v.cpu_req = c;   v.cpu_we = cwe;  v.cpu_addr = ca; v.cpu_wdata = cd;
      v.cpu_lock = cl; v.gpu_req = g;   v.gpu_addr = ga;
      return v;
   endfunction

   function automatic out_t fn_out(input logic [2:0] g, input logic rd, input logic wr,
                                   input logic [AW-1:0] a, input logic [7:0] wd,
                                   input logic crv, input logic grv, input logic [7:0] rdat,
                                   input logic bsy);
      out_t o;
      o.gnt = g; o.rd = rd; o.wr = wr; o.addr = a; o.wdata = wd;
      o.cpu_rv = crv; o.gpu_rv = grv; o.rdata = rdat; o.busy = bsy;
      return o;
   endfunction

   function automatic in_t in_rst(input in_t v);
      in_t r = v;
      r.rst_n = 1'b0;
      return r;
   endfunction

   task automatic chk(input string tag, input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s.%s cycle %0d: got 0x%0h, expected 0x%0h", tag, nm, cyc, act, exp);
   endtask

   task automatic drive(input in_t v);
      rst_n         = v.rst_n;
      bus.ld_req    = v.ld_req;
      bus.ld_addr   = v.ld_addr;
      bus.ld_wdata  = v.ld_wdata;
      bus.cpu_req   = v.cpu_req;
      bus.cpu_we    = v.cpu_we;
      bus.cpu_addr  = v.cpu_addr;
      bus.cpu_wdata = v.cpu_wdata;
      bus.cpu_lock  = v.cpu_lock;
      bus.gpu_req   = v.gpu_req;
      bus.gpu_addr  = v.gpu_addr;
   endtask

   task automatic compare(input out_t e, input string tag);
      chk(tag, "gnt", 32'({bus.ld_gnt, bus.cpu_gnt, bus.gpu_gnt}), 32'(e.gnt));
      chk(tag, "mem_read", 32'(bus.mem_read), 32'(e.rd));
      chk(tag, "mem_write", 32'(bus.mem_write), 32'(e.wr));
      if (e.rd) chk(tag, "mem_read_addr", 32'(bus.mem_read_addr), 32'(e.addr));
      if (e.wr) begin
         chk(tag, "mem_write_addr", 32'(bus.mem_write_addr), 32'(e.addr));
         chk(tag, "mem_write_data", 32'(bus.mem_write_data), 32'(e.wdata));
      end
      chk(tag, "cpu_rvalid", 32'(bus.cpu_rvalid), 32'(e.cpu_rv));
      chk(tag, "gpu_rvalid", 32'(bus.gpu_rvalid), 32'(e.gpu_rv));
      if (e.cpu_rv || e.gpu_rv) chk(tag, "rdata", 32'(bus.rdata), 32'(e.rdata));
      chk(tag, "busy", 32'(bus.busy), 32'(e.busy));
   endtask

   // One cycle: drive at negedge, compare mid-cycle, advance the model, then clock.
   task automatic step(input in_t v, input out_t e, input bit use_tbl, input string tag);
      out_t m;
      int   win;  // 0 none, 1 loader, 2 cpu, 3 gpu
      bit   gpu_ok;
      @(negedge clk);
      drive(v);
      #1;
      if (!v.rst_n) begin
         m_rr = 1'b0;
         m_locked = 1'b0;
         m_q.delete();
      end
      gpu_ok = v.gpu_req && !m_locked;
      win = 0;
      if (!v.rst_n)                   win = 0;
      else if (v.ld_req)              win = 1;
      else if (v.cpu_req && gpu_ok)   win = m_rr ? 3 : 2;
      else if (v.cpu_req)             win = 2;
      else if (gpu_ok)                win = 3;

      m = '0;
      case (win)
         1: begin m.gnt = 3'b100; m.wr = 1'b1; m.addr = v.ld_addr; m.wdata = v.ld_wdata; end
         2: begin
            m.gnt = 3'b010; m.addr = v.cpu_addr;
            if (v.cpu_we) begin m.wr = 1'b1; m.wdata = v.cpu_wdata; end
            else m.rd = 1'b1;
         end
         3: begin m.gnt = 3'b001; m.rd = 1'b1; m.addr = v.gpu_addr; end
         default: ;
      endcase
      if (m_q.size() > 0 && m_q[0].due == cyc) begin
         if (m_q[0].is_gpu) m.gpu_rv = 1'b1;
         else               m.cpu_rv = 1'b1;
         m.rdata = m_q[0].data;
      end
      m.busy = v.ld_req | v.cpu_req | v.gpu_req | m.cpu_rv | m.gpu_rv;

      compare(use_tbl ? e : m, tag);

      while (m_q.size() > 0 && m_q[0].due <= cyc) void'(m_q.pop_front());
      case (win)
         1: ref_mem[int'(v.ld_addr)] = v.ld_wdata;
         2: begin
            m_rr = 1'b1;
            if (v.cpu_we) ref_mem[int'(v.cpu_addr)] = v.cpu_wdata;
            else m_q.push_back('{due: cyc + 1, is_gpu: 1'b0, data: ref_rd(v.cpu_addr)});
         end
         3: begin
            m_rr = 1'b0;
            m_q.push_back('{due: cyc + 1, is_gpu: 1'b1, data: ref_rd(v.gpu_addr)});
         end
         default: ;
      endcase
      if (m_locked) m_locked = v.cpu_lock;
      else if (win == 2 && v.cpu_lock) m_locked = 1'b1;

      s_gnt = {bus.ld_gnt, bus.cpu_gnt, bus.gpu_gnt};
      @(posedge clk);
      cyc++;
   endtask

   initial begin
      vec_t vecs[$];
      in_t  idle;
      in_t  v;
      in_t  cur;
      out_t none;
      out_t zero;

      idle = fn_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      none = '0;
      zero = fn_out(3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(in_rst(idle));

      // reset: requests visible on busy only
      vecs.push_back('{in_rst(fn_in(0, 0, 0, 1, 0, 'h200, 0, 0, 1, 'h123)), fn_out(3'b000, 0, 0, 0, 0, 0, 0, 0, 1)});
      vecs.push_back('{in_rst(idle), zero});
      vecs.push_back('{idle, zero});
      // CPU read, write, read-back
      vecs.push_back('{fn_in(0, 0, 0, 1, 0, 'h200, 0, 0, 0, 0), fn_out(3'b010, 1, 0, 'h200, 0, 0, 0, 0, 1)});
      vecs.push_back('{idle, fn_out(3'b000, 0, 0, 0, 0, 1, 0, 'hA2, 1)});
      vecs.push_back('{fn_in(0, 0, 0, 1, 1, 'h210, 'h55, 0, 0, 0), fn_out(3'b010, 0, 1, 'h210, 'h55, 0, 0, 0, 1)});
      vecs.push_back('{fn_in(0, 0, 0, 1, 0, 'h210, 0, 0, 0, 0), fn_out(3'b010, 1, 0, 'h210, 0, 0, 0, 0, 1)});
      vecs.push_back('{idle, fn_out(3'b000, 0, 0, 0, 0, 1, 0, 'h55, 1)});
      vecs.push_back('{idle, zero});
      // GPU read brings rr back to 0, then loader burst over both
      vecs.push_back('{fn_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h123), fn_out(3'b001, 1, 0, 'h123, 0, 0, 0, 0, 1)});
      vecs.push_back('{fn_in(1, 'h200, 'h11, 1, 0, 'h201, 0, 0, 1, 'h124), fn_out(3'b100, 0, 1, 'h200, 'h11, 0, 1, 'h7E, 1)});
      vecs.push_back('{fn_in(1, 'h201, 'h12, 1, 0, 'h201, 0, 0, 1, 'h124), fn_out(3'b100, 0, 1, 'h201, 'h12, 0, 0, 0, 1)});
      vecs.push_back('{fn_in(1, 'h202, 'h13, 1, 0, 'h201, 0, 0, 1, 'h124), fn_out(3'b100, 0, 1, 'h202, 'h13, 0, 0, 0, 1)});
      vecs.push_back('{fn_in(0, 0, 0, 1, 0, 'h201, 0, 0, 1, 'h124), fn_out(3'b010, 1, 0, 'h201, 0, 0, 0, 0, 1)});
      vecs.push_back('{fn_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h124), fn_out(3'b001, 1, 0, 'h124, 0, 1, 0, 'h12, 1)});
      // continuous CPU+GPU: alternating grants, one response per cycle
      vecs.push_back('{fn_in(0, 0, 0, 1, 0, 'h200, 0, 0, 1, 'h202), fn_out(3'b010, 1, 0, 'h200, 0, 0, 1, 'h24, 1)});
      vecs.push_back('{fn_in(0, 0, 0, 1, 0, 'h202, 0, 0, 1, 'h202), fn_out(3'b001, 1, 0, 'h202, 0, 1, 0, 'h11, 1)});
      vecs.push_back('{fn_in(0, 0, 0, 1, 0, 'h202, 0, 0, 1, 'h200), fn_out(3'b010, 1, 0, 'h202, 0, 0, 1, 'h13, 1)});
      vecs.push_back('{fn_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h200), fn_out(3'b001, 1, 0, 'h200, 0, 1, 0, 'h13, 1)});
      vecs.push_back('{idle, fn_out(3'b000, 0, 0, 0, 0, 0, 1, 'h11, 1)});
      vecs.push_back('{idle, zero});
      // CPU lock holds the GPU off until the cycle after cpu_lock drops
      vecs.push_back('{fn_in(0, 0, 0, 1, 0, 'h300, 0, 1, 1, 'h301), fn_out(3'b010, 1, 0, 'h300, 0, 0, 0, 0, 1)});
      vecs.push_back('{fn_in(0, 0, 0, 1, 0, 'h301, 0, 1, 1, 'h301), fn_out(3'b010, 1, 0, 'h301, 0, 1, 0, 'h30, 1)});
      vecs.push_back('{fn_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h301), fn_out(3'b000, 0, 0, 0, 0, 1, 0, 'h31, 1)});
      vecs.push_back('{fn_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h301), fn_out(3'b001, 1, 0, 'h301, 0, 0, 0, 0, 1)});
      vecs.push_back('{idle, fn_out(3'b000, 0, 0, 0, 0, 0, 1, 'h31, 1)});
      vecs.push_back('{idle, zero});

      foreach (vecs[i]) step(vecs[i].in, vecs[i].exp, 1'b1, $sformatf("vec%0d", i));

      // reset right after a GPU read grant cancels its response; rr restarts at 0
      step(fn_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h050), fn_out(3'b001, 1, 0, 'h050, 0, 0, 0, 0, 1), 1'b1, "rst_gpu_gnt");
      #1 rst_n = 1'b0;
      v = in_rst(fn_in(0, 0, 0, 1, 0, 'h060, 0, 0, 1, 'h050));
      step(v, fn_out(3'b000, 0, 0, 0, 0, 0, 0, 0, 1), 1'b1, "rst_cancel");
      step(v, fn_out(3'b000, 0, 0, 0, 0, 0, 0, 0, 1), 1'b1, "rst_hold");
      step(fn_in(0, 0, 0, 1, 0, 'h060, 0, 0, 1, 'h050), fn_out(3'b010, 1, 0, 'h060, 0, 0, 0, 0, 1), 1'b1, "rst_rr0");
      step(fn_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h050), fn_out(3'b001, 1, 0, 'h050, 0, 1, 0, 'h3A, 1), 1'b1, "post_rst_gpu");
      step(idle, fn_out(3'b000, 0, 0, 0, 0, 0, 1, 'h0A, 1), 1'b1, "post_rst_idle");

      // reset while LOCKED returns to OPEN even with cpu_lock still high
      step(fn_in(0, 0, 0, 1, 0, 'h070, 0, 1, 0, 0), fn_out(3'b010, 1, 0, 'h070, 0, 0, 0, 0, 1), 1'b1, "lock_pre_rst");
      #1 rst_n = 1'b0;
      step(in_rst(fn_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0)), zero, 1'b1, "lock_rst");
      step(fn_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 'h071), fn_out(3'b001, 1, 0, 'h071, 0, 0, 0, 0, 1), 1'b1, "open_after_rst");
      step(idle, fn_out(3'b000, 0, 0, 0, 0, 0, 1, 'h2B, 1), 1'b1, "open_resp");
      step(idle, zero, 1'b1, "quiet");

      // randomized requesters honouring hold-until-grant
      cur = idle;
      for (int c = 0; c < 2000; c++) begin
         if (!cur.ld_req || s_gnt[2]) begin
            cur.ld_req   = ($urandom_range(0, 3) == 0);
            cur.ld_addr  = AW'($urandom_range(0, 31));
            cur.ld_wdata = 8'($urandom);
         end
         if (!cur.cpu_req || s_gnt[1]) begin
            cur.cpu_req   = ($urandom_range(0, 1) == 0);
            cur.cpu_we    = ($urandom_range(0, 2) == 0);
            cur.cpu_addr  = AW'($urandom_range(0, 31));
            cur.cpu_wdata = 8'($urandom);
         end
         if (!cur.gpu_req || s_gnt[0]) begin
            cur.gpu_req  = ($urandom_range(0, 1) == 0);
            cur.gpu_addr = AW'($urandom_range(0, 31));
         end
         cur.cpu_lock = ($urandom_range(0, 3) == 0);
         step(cur, none, 1'b0, "rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
